// File: rtl/adpcm_pkg.sv
// Shared definitions for the adpcm encode-side packer: widths, Gray-coded FSM states,
// watchdog limits and the nibble-pair packing helper.
`ifndef ADPCM_GRAY
`define ADPCM_GRAY(i) ((i) ^ ((i) >> 1))
`endif

package adpcm_pkg;

  localparam int PCM_W  = 16;
  localparam int CODE_W = 4;
  localparam int WD_W   = 5;

  localparam logic [WD_W-1:0] WD_BUSY_LIM = 5'd3;
  localparam logic [WD_W-1:0] WD_DONE_LIM = 5'd15;

  // Successive states differ in one bit along the normal conversion path.
  typedef enum logic [2:0] {
    ST_IDLE      = 3'(`ADPCM_GRAY(0)),
    ST_ISSUE     = 3'(`ADPCM_GRAY(1)),
    ST_WAIT_BUSY = 3'(`ADPCM_GRAY(2)),
    ST_WAIT_DONE = 3'(`ADPCM_GRAY(3)),
    ST_PACK      = 3'(`ADPCM_GRAY(4))
  } st_e;

  function automatic logic [7:0] pack_byte(input logic [CODE_W-1:0] first,
                                           input logic [CODE_W-1:0] second,
                                           input logic              hi_first);
    pack_byte = hi_first ? {first, second} : {second, first};
  endfunction

endpackage

// File: rtl/adpcm_tx_packer_if.sv
// Sample-in / byte-out stream bundle for the adpcm encode-side packer.
interface adpcm_tx_packer_if;

  logic [adpcm_pkg::PCM_W-1:0] s_pcm;
  logic                        s_valid;
  logic                        s_ready;
  logic [7:0]                  m_byte;
  logic                        m_valid;
  logic                        m_ready;

  // Both streams: a beat transfers on the rising clk edge where valid and ready are both
  // high; a source holds valid and keeps its data stable until that edge, and ready may
  // depend combinationally on valid but never the other way round.
  modport master (
    output s_pcm, s_valid, m_ready,
    input  s_ready, m_byte, m_valid
  );

  modport slave (
    input  s_pcm, s_valid, m_ready,
    output s_ready, m_byte, m_valid
  );

endinterface

// File: rtl/adpcm_byte_fifo.sv
// Byte FIFO with first-word-fall-through head, async active-low reset and synchronous clear.
module adpcm_byte_fifo #(
  parameter int FIFO_AW = 3
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             clr,
  input  logic             push,
  input  logic [7:0]       data_in,
  input  logic             pop,
  output logic [7:0]       data_out,
  output logic [FIFO_AW:0] level,
  output logic             full,
  output logic             empty
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam logic [FIFO_AW:0] DEPTH_V = (FIFO_AW + 1)'(DEPTH);

  logic [7:0]       mem [DEPTH];
  logic [FIFO_AW:0] wptr;
  logic [FIFO_AW:0] rptr;
  logic             do_push;
  logic             do_pop;

  // Pointers carry one extra bit so full and empty stay distinguishable.
  assign level    = wptr - rptr;
  assign full     = (level == DEPTH_V);
  assign empty    = (level == '0);
  assign do_pop   = pop & ~empty;
  assign do_push  = push & (~full | do_pop);
  assign data_out = mem[rptr[FIFO_AW-1:0]];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wptr <= '0;
      rptr <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (clr) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) begin
        mem[wptr[FIFO_AW-1:0]] <= data_in;
        wptr                   <= wptr + 1'b1;
      end
      if (do_pop) rptr <= rptr + 1'b1;
    end
  end

endmodule

// File: rtl/adpcm_tx_packer.sv
// Encode-side glue: PCM stream -> adpcm codec toggle handshake -> nibble packer -> byte FIFO.
// Define ADPCM_TX_PACKER_TIMEOUT_EN to add a sticky err output and a codec-handshake watchdog.
module adpcm_tx_packer
  import adpcm_pkg::*;
#(
  parameter int FIFO_AW  = 3,
  parameter bit HI_FIRST = 1'b0
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               enable,
  adpcm_tx_packer_if.slave   bus,
  input  logic               flush,
  output logic               codec_req,
  input  logic               codec_ack,
  output logic [PCM_W-1:0]   codec_pcm,
  output logic               codec_sel_rx,
  input  logic [CODE_W-1:0]  codec_adpcm,
  output logic [FIFO_AW:0]   fifo_level,
  output logic               odd_pending,
  output logic               busy,
  output st_e                dbg_state
`ifdef ADPCM_TX_PACKER_TIMEOUT_EN
  ,
  output logic               err
`endif
);

  st_e               state;
  st_e               state_nx;
  logic              idle;
  logic              accept;
  logic              toggle_req;
  logic              flush_pend;
  logic              flush_eff;
  logic              flush_do;
  logic              pack_push;
  logic [CODE_W-1:0] hold_q;
  logic [CODE_W-1:0] code_q;
  logic              fifo_push;
  logic              fifo_pop;
  logic              fifo_full;
  logic              fifo_empty;
  logic [7:0]        fifo_din;
  logic [7:0]        fifo_dout;

`ifdef ADPCM_TX_PACKER_TIMEOUT_EN
  logic [WD_W-1:0]   wdog;
  logic              timeout;
`endif

  assign idle         = (state == ST_IDLE);
  assign busy         = ~idle;
  assign dbg_state    = state;
  assign codec_sel_rx = 1'b0;

  // A flush raised while busy waits in flush_pend and is served by the first idle cycle,
  // which also holds off the next accept so the flushed byte goes out first.
  assign flush_eff   = flush | flush_pend;
  assign bus.s_ready = enable & idle & codec_ack & ~fifo_full & ~flush_eff;
  assign accept      = bus.s_valid & bus.s_ready;
  assign flush_do    = idle & flush_eff & odd_pending & ~fifo_full;
  assign pack_push   = (state == ST_PACK) & odd_pending;

  assign fifo_push = pack_push | flush_do;
  assign fifo_din  = pack_push ? pack_byte(hold_q, code_q, HI_FIRST)
                               : pack_byte(hold_q, 4'h0, HI_FIRST);
  assign fifo_pop  = ~fifo_empty & bus.m_ready;

  assign bus.m_valid = ~fifo_empty;
  assign bus.m_byte  = fifo_dout;

  always_comb begin
    state_nx   = state;
    toggle_req = 1'b0;
`ifdef ADPCM_TX_PACKER_TIMEOUT_EN
    timeout    = 1'b0;
`endif
    unique case (state)
      ST_IDLE: begin
        if (accept) state_nx = ST_ISSUE;
      end
      ST_ISSUE: begin
        toggle_req = 1'b1;
        state_nx   = ST_WAIT_BUSY;
      end
      ST_WAIT_BUSY: begin
        if (!codec_ack) state_nx = ST_WAIT_DONE;
`ifdef ADPCM_TX_PACKER_TIMEOUT_EN
        else if (wdog == WD_BUSY_LIM) begin
          timeout  = 1'b1;
          state_nx = ST_IDLE;
        end
`endif
      end
      ST_WAIT_DONE: begin
        if (codec_ack) state_nx = ST_PACK;
`ifdef ADPCM_TX_PACKER_TIMEOUT_EN
        else if (wdog == WD_DONE_LIM) begin
          timeout  = 1'b1;
          state_nx = ST_IDLE;
        end
`endif
      end
      ST_PACK: begin
        state_nx = ST_IDLE;
      end
      default: begin
        state_nx = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state       <= ST_IDLE;
      codec_req   <= 1'b0;
      codec_pcm   <= '0;
      hold_q      <= '0;
      code_q      <= '0;
      odd_pending <= 1'b0;
      flush_pend  <= 1'b0;
    end else if (!enable) begin
      state       <= ST_IDLE;
      codec_req   <= 1'b0;
      codec_pcm   <= '0;
      hold_q      <= '0;
      code_q      <= '0;
      odd_pending <= 1'b0;
      flush_pend  <= 1'b0;
    end else begin
      state <= state_nx;
      if (accept)     codec_pcm <= bus.s_pcm;
      if (toggle_req) codec_req <= ~codec_req;
      // The codec presents its code together with the rising ack.
      if ((state == ST_WAIT_DONE) && codec_ack) code_q <= codec_adpcm;
      if (state == ST_PACK) begin
        if (!odd_pending) begin
          hold_q      <= code_q;
          odd_pending <= 1'b1;
        end else begin
          odd_pending <= 1'b0;
        end
      end else if (flush_do) begin
        odd_pending <= 1'b0;
      end
      flush_pend <= idle ? 1'b0 : (flush_pend | flush);
    end
  end

`ifdef ADPCM_TX_PACKER_TIMEOUT_EN
  // wdog counts whole cycles spent in the current state and restarts on every change.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wdog <= '0;
      err  <= 1'b0;
    end else if (!enable) begin
      wdog <= '0;
      err  <= 1'b0;
    end else begin
      if (state_nx != state) wdog <= '0;
      else if (wdog != '1)   wdog <= wdog + 1'b1;
      if (timeout) err <= 1'b1;
    end
  end
`endif

  adpcm_byte_fifo #(
    .FIFO_AW (FIFO_AW)
  ) u_fifo (
    .clk      (clk),
    .rstn     (rstn),
    .clr      (~enable),
    .push     (fifo_push),
    .data_in  (fifo_din),
    .pop      (fifo_pop),
    .data_out (fifo_dout),
    .level    (fifo_level),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

endmodule

// File: doc/adpcm_tx_packer.md
Name: adpcm_tx_packer

Overview:
Upstream/downstream glue around the adpcm codec in encode mode. Accepts 16-bit PCM samples on a valid/ready stream, drives the codec's toggle-req/ack handshake with sel_rx held low, and captures each 4-bit code. Packs codes two per byte, low nibble first, into a small byte FIFO. Emits bytes on a valid/ready stream toward the serial/storage side.

Parameters:
FIFO_AW, 3, FIFO address width; depth = 2**FIFO_AW bytes
HI_FIRST, 0, 0 = first code of a pair in bits [3:0]; 1 = first code in bits [7:4]

Ports:
clk  in  1  system clock, all logic on posedge
rstn  in  1  asynchronous active-low reset
enable  in  1  synchronous clear when low (matches codec enable)
s_pcm  in  16  signed PCM sample
s_valid  in  1  sample valid
s_ready  out  1  sample accepted when s_valid & s_ready
flush  in  1  pulse; pad and push a pending odd nibble
codec_req  out  1  toggle-style request to codec req
codec_ack  in  1  codec ack (high = codec idle)
codec_pcm  out  16  registered sample to codec rx_pcm
codec_sel_rx  out  1  constant 0 (encode)
codec_adpcm  in  4  codec tx_adpcm
m_byte  out  8  packed byte
m_valid  out  1  FIFO not empty
m_ready  in  1  byte consumed when m_valid & m_ready
fifo_level  out  FIFO_AW+1  bytes held
odd_pending  out  1  one nibble held awaiting its pair
busy  out  1  FSM not in ST_IDLE

Behaviour:
- Reset (rstn low, async) and enable low (sync): FSM=ST_IDLE, codec_req=0, codec_pcm=0, nibble hold=0, odd_pending=0, FIFO pointers=0, m_valid=0, m_byte=FIFO head (0 after reset), fifo_level=0.
- Reset/enable-low mid-conversion aborts; the partial nibble is discarded; no byte pushed.
- FSM states, Gray-coded: ST_IDLE, ST_ISSUE, ST_WAIT_BUSY, ST_WAIT_DONE, ST_PACK.
- ST_IDLE: s_ready = codec_ack & (fifo_level < depth) & !flush. On accept, codec_pcm <= s_pcm and go to ST_ISSUE.
- ST_ISSUE: one cycle. codec_pcm is stable, so the codec samples its diff. Toggle codec_req; go to ST_WAIT_BUSY.
- ST_WAIT_BUSY: wait for codec_ack==0 (expected the next cycle), then go to ST_WAIT_DONE.
- ST_WAIT_DONE: wait for codec_ack==1. At that edge codec_adpcm is valid; capture it, then go to ST_PACK.
- ST_PACK: one cycle.
  - If !odd_pending: hold nibble, odd_pending <= 1.
  - Else: push {new,held} (HI_FIRST=0) or {held,new} (HI_FIRST=1); odd_pending <= 0.
  - Return to ST_IDLE.
  - The push cannot overflow because the s_ready gate guarantees a free slot.
- Sample-to-byte latency: codec latency + 3 FSM cycles; nominally 10 clk from accept to FIFO push.
- flush in ST_IDLE with odd_pending: push held nibble with the other nibble 0; clear odd_pending.
- flush in ST_IDLE with no pending nibble: no effect.
- flush in any other state: latched and applied on return to ST_IDLE, before the next accept.
- FIFO push and pop in the same cycle: level unchanged. Full with pop: push allowed.
- Pointers are FIFO_AW+1 bits and wrap naturally.
- m_byte is the combinational head of the FIFO. It is stable while m_valid & !m_ready.
- codec_req is never toggled while codec_ack==0.

Optional Feature:
ADPCM_TX_PACKER_TIMEOUT_EN:
- With: adds output err (1 bit, sticky, cleared by reset/enable-low) and a 5-bit watchdog.
  - ST_WAIT_BUSY lasting more than 3 cycles, or ST_WAIT_DONE lasting more than 15 cycles, sets err.
  - The FSM returns to ST_IDLE, discards the nibble and leaves odd_pending unchanged.
- Without: no err port; the FSM waits indefinitely.

Decomposition:
- Shared package adpcm_pkg:
  - Gray state-encoding macro and the 5 ST_* encodings.
  - PCM width 16, code width 4.
  - Watchdog limits 3/15.
- Sub-module adpcm_byte_fifo:
  - Parameterised by FIFO_AW.
  - Ports push/data_in/pop/data_out/level/full/empty.
  - Async active-low reset plus synchronous clear.

Test Plan:
- Two samples with stub codec returning 0x3 then 0xA, m_ready=1 -> one byte 0xA3 (HI_FIRST=0), odd_pending back to 0, codec_req toggled twice, codec_sel_rx=0 throughout.
- Three samples (codes 0x1,0x2,0x5) then flush -> bytes 0x21 then 0x05; fifo_level 2.
- m_ready=0, 18 samples with FIFO_AW=3 -> fifo_level reaches 8, s_ready stays 0 with 2 samples un-accepted. Raise m_ready -> bytes drain in order and the two remaining samples are accepted.
- Drop rstn during ST_WAIT_DONE -> all outputs reset immediately. The next two samples (codes 0x7,0x8) yield 0x87 with no stale nibble.
- Simultaneous push and pop at level 8 -> level stays 8, no byte lost or duplicated; scoreboard matches sequence.
- With ADPCM_TX_PACKER_TIMEOUT_EN, stub holds codec_ack=1 after the toggle -> err=1 after 4 cycles in ST_WAIT_BUSY, FSM returns to ST_IDLE, no push.
